// File: rtl/friction_decay.sv
// Geometric friction on a 3D signed velocity: v <= v - (v >>> SHIFT) per tick,
// with a snap to zero once every component is inside +/-2^TOL, or after MAX_STEPS ticks.
module friction_decay #(
  parameter  int WIDTH     = 32,
  parameter  int TOL       = 10,
  parameter  int SHIFT     = 4,
  parameter  int MAX_STEPS = 1023,
  localparam int CW        = $clog2(MAX_STEPS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic signed [WIDTH-1:0] vx_in,
  input  logic signed [WIDTH-1:0] vy_in,
  input  logic signed [WIDTH-1:0] vz_in,
  input  logic                    step,
  input  logic                    abort,
  output logic signed [WIDTH-1:0] vx,
  output logic signed [WIDTH-1:0] vy,
  output logic signed [WIDTH-1:0] vz,
  output logic                    busy,
  output logic                    stopped,
  output logic                    timeout,
  output logic [CW-1:0]           step_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DECAY = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic signed [WIDTH-1:0] HI = WIDTH'(2 ** TOL);
  localparam logic signed [WIDTH-1:0] LO = -HI;

  state_t state, state_next;

  logic          load;
  logic          snap;
  logic          force_stop;
  logic          decay;
  logic          advance;
  logic          near;
  logic [CW-1:0] count_inc;

  function automatic logic in_window(input logic signed [WIDTH-1:0] v);
    return (v >= LO) && (v <= HI);
  endfunction

  // Subtracting v >>> SHIFT keeps the sign and cannot overflow, even at the most negative value.
  function automatic logic signed [WIDTH-1:0] damp(input logic signed [WIDTH-1:0] v);
    return v - (v >>> SHIFT);
  endfunction

  assign near      = in_window(vx) && in_window(vy) && in_window(vz);
  assign count_inc = step_count + CW'(1);

  always_comb begin
    state_next  = state;
    load        = 1'b0;
    snap        = 1'b0;
    force_stop  = 1'b0;
    decay       = 1'b0;
    advance     = 1'b0;
    start_ready = 1'b0;
    busy        = 1'b0;
    stopped     = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          load       = 1'b1;
          state_next = DECAY;
        end
      end
      DECAY: begin
        busy = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else if (step) begin
          advance = 1'b1;
          if (near) begin
            snap       = 1'b1;
            state_next = DONE;
          end else if (count_inc == CW'(MAX_STEPS)) begin
            snap       = 1'b1;
            force_stop = 1'b1;
            state_next = DONE;
          end else begin
            decay = 1'b1;
          end
        end
      end
      DONE: begin
        stopped    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vx         <= '0;
      vy         <= '0;
      vz         <= '0;
      timeout    <= 1'b0;
      step_count <= '0;
    end else begin
      if (load) begin
        vx         <= vx_in;
        vy         <= vy_in;
        vz         <= vz_in;
        timeout    <= 1'b0;
        step_count <= '0;
      end else begin
        if (snap) begin
          vx <= '0;
          vy <= '0;
          vz <= '0;
        end else if (decay) begin
          vx <= damp(vx);
          vy <= damp(vy);
          vz <= damp(vz);
        end
        if (force_stop) begin
          timeout <= 1'b1;
        end
        if (advance) begin
          step_count <= count_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_friction_decay.sv
// Directed bench for friction_decay: a vector table of single runs plus hand-written
// sequences for timeout, overflow, abort, ignored loads and asynchronous reset.
module tb_friction_decay;

  logic               clk = 1'b0;
  logic               rst;
  logic               start_valid;
  logic signed [31:0] vx_in, vy_in, vz_in;
  logic               step;
  logic               abort;

  logic               start_ready, busy, stopped, timeout;
  logic signed [31:0] vx, vy, vz;
  logic [9:0]         step_count;

  logic               start_ready4, busy4, stopped4, timeout4;
  logic signed [31:0] vx4, vy4, vz4;
  logic [2:0]         step_count4;

  int n_pass  = 0;
  int n_total = 0;

  friction_decay dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .vx_in(vx_in), .vy_in(vy_in), .vz_in(vz_in), .step(step), .abort(abort),
    .vx(vx), .vy(vy), .vz(vz), .busy(busy), .stopped(stopped), .timeout(timeout),
    .step_count(step_count)
  );

  friction_decay #(.MAX_STEPS(4)) dut4 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready4),
    .vx_in(vx_in), .vy_in(vy_in), .vz_in(vz_in), .step(step), .abort(abort),
    .vx(vx4), .vy(vy4), .vz(vz4), .busy(busy4), .stopped(stopped4), .timeout(timeout4),
    .step_count(step_count4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [31:0] x, y, z;
    int unsigned        n;
    logic signed [31:0] ex, ey, ez;
    logic [9:0]         esc;
    logic               estop;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic load(input logic signed [31:0] x, y, z);
    vx_in = x; vy_in = y; vz_in = z;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  task automatic tick();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic settle();
    if (busy || busy4) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{x: 4096,  y: 0,    z: 0,    n: 1,  ex: 3840,  ey: 0,    ez: 0,   esc: 1,  estop: 0};
    vecs[1] = '{x: 4096,  y: 0,    z: 0,    n: 3,  ex: 3375,  ey: 0,    ez: 0,   esc: 3,  estop: 0};
    vecs[2] = '{x: 4096,  y: 0,    z: 0,    n: 22, ex: 996,   ey: 0,    ez: 0,   esc: 22, estop: 0};
    vecs[3] = '{x: -1024, y: 1024, z: 0,    n: 1,  ex: 0,     ey: 0,    ez: 0,   esc: 1,  estop: 1};
    vecs[4] = '{x: 1025,  y: 0,    z: 0,    n: 1,  ex: 961,   ey: 0,    ez: 0,   esc: 1,  estop: 0};
    vecs[5] = '{x: 1025,  y: 0,    z: 0,    n: 2,  ex: 0,     ey: 0,    ez: 0,   esc: 2,  estop: 1};
    vecs[6] = '{x: 32'sh8000_0000, y: 0, z: 0, n: 1, ex: -2013265920, ey: 0, ez: 0, esc: 1, estop: 0};
    vecs[7] = '{x: -4096, y: 2048, z: -100, n: 1,  ex: -3840, ey: 1920, ez: -93, esc: 1,  estop: 0};
    vecs[8] = '{x: 1024,  y: -1025, z: 0,   n: 1,  ex: 960,   ey: -960, ez: 0,   esc: 1,  estop: 0};

    rst = 1'b1; start_valid = 1'b0; step = 1'b0; abort = 1'b0;
    vx_in = '0; vy_in = '0; vz_in = '0;
    repeat (2) @(negedge clk);
    chk("reset vx", vx, 0);
    chk("reset step_count", step_count, 0);
    chk("reset start_ready", start_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset stopped", stopped, 0);
    chk("reset timeout", timeout, 0);
    rst = 1'b0;
    @(negedge clk);

    // Table: load, apply n consecutive steps, check the state right after the last one.
    for (int i = 0; i < 9; i++) begin
      load(vecs[i].x, vecs[i].y, vecs[i].z);
      for (int unsigned k = 0; k < vecs[i].n; k++) tick();
      chk($sformatf("vec%0d vx", i), vx, vecs[i].ex);
      chk($sformatf("vec%0d vy", i), vy, vecs[i].ey);
      chk($sformatf("vec%0d vz", i), vz, vecs[i].ez);
      chk($sformatf("vec%0d step_count", i), step_count, vecs[i].esc);
      chk($sformatf("vec%0d stopped", i), stopped, vecs[i].estop);
      settle();
    end

    // Full run: step 23 snaps, single-cycle stopped pulse.
    load(4096, 0, 0);
    chk("load busy", busy, 1);
    chk("load start_ready", start_ready, 0);
    for (int k = 0; k < 23; k++) tick();
    chk("run vx", vx, 0);
    chk("run stopped", stopped, 1);
    chk("run busy", busy, 0);
    chk("run step_count", step_count, 23);
    chk("run timeout", timeout, 0);
    @(negedge clk);
    chk("run stopped drops", stopped, 0);
    chk("run start_ready", start_ready, 1);
    chk("run vx holds", vx, 0);
    settle();

    // MAX_STEPS=4 instance: forced stop on the 4th step.
    load(4096, 4096, -4096);
    for (int k = 0; k < 3; k++) tick();
    chk("to vx step3", vx4, 3375);
    chk("to vz step3", vz4, -3375);
    chk("to timeout step3", timeout4, 0);
    tick();
    chk("to vx", vx4, 0);
    chk("to vy", vy4, 0);
    chk("to vz", vz4, 0);
    chk("to timeout", timeout4, 1);
    chk("to stopped", stopped4, 1);
    chk("to step_count", step_count4, 4);
    @(negedge clk);
    chk("to stopped drops", stopped4, 0);
    chk("to timeout sticky", timeout4, 1);
    settle();
    load(1025, 0, 0);
    chk("to cleared by load", timeout4, 0);
    chk("to reload vx", vx4, 1025);
    settle();

    // Most negative value: no overflow, sign stays negative until the snap.
    begin
      logic sign_ok;
      int   k;
      load(32'sh8000_0000, 0, 0);
      tick();
      chk("neg step1", vx, -2013265920);
      sign_ok = 1'b1;
      k = 1;
      while (busy && k < 1100) begin
        tick();
        k++;
        if (busy && vx >= 0) sign_ok = 1'b0;
      end
      chk("neg sign kept", sign_ok, 1);
      chk("neg stopped", stopped, 1);
      chk("neg vx", vx, 0);
      chk("neg timeout", timeout, 0);
      settle();
    end

    // Abort wins over step; start_valid in DECAY ignored.
    load(4096, 0, 0);
    tick();
    vx_in = 100; vy_in = 100; vz_in = 100;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    chk("ign vx", vx, 3840);
    chk("ign vy", vy, 0);
    chk("ign busy", busy, 1);
    chk("ign step_count", step_count, 1);
    abort = 1'b1; step = 1'b1;
    @(negedge clk);
    abort = 1'b0; step = 1'b0;
    chk("abort vx", vx, 3840);
    chk("abort stopped", stopped, 0);
    chk("abort start_ready", start_ready, 1);
    chk("abort step_count", step_count, 1);
    @(negedge clk);
    chk("abort no pulse", stopped, 0);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("idle step ignored", vx, 3840);

    // Asynchronous reset between edges, then a clean rerun.
    load(4096, 0, 0);
    for (int k = 0; k < 3; k++) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst vx", vx, 0);
    chk("arst step_count", step_count, 0);
    chk("arst start_ready", start_ready, 1);
    chk("arst busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load(4096, 0, 0);
    for (int k = 0; k < 22; k++) tick();
    chk("rerun step22", vx, 996);
    tick();
    chk("rerun vx", vx, 0);
    chk("rerun stopped", stopped, 1);
    chk("rerun step_count", step_count, 23);
    chk("rerun timeout", timeout, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
